new_decoder: RTL and testbench

- Parameterised N-to-2^N one-hot binary decoder with active-high enable and a registered output stage.
- Adds a registered valid flag and a sticky "seen" bitmap of every code decoded since reset or clear.
- Sits as a generic address/select decoder in datapaths; its combinational core is reusable on its own.

---
 rtl/new_decoder_pkg.sv | 14 +
 rtl/new_decoder_core.sv | 30 +++
 rtl/new_decoder.sv | 53 +++++
 tb/tb_new_decoder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/new_decoder_pkg.sv
// Shared constants and the one-hot helper used by the decoder core.
// The helper works at the widest legal size; callers keep the low 2**N bits.
package new_decoder_pkg;

    localparam int N_MAX     = 8;
    localparam int W_MAX     = 2 ** N_MAX;
    localparam int DEFAULT_N = 3;
    localparam int DEFAULT_W = 2 ** DEFAULT_N;

    function automatic logic [W_MAX-1:0] onehot_of(input logic [N_MAX-1:0] code);
        onehot_of = W_MAX'(1) << code;
    endfunction

endpackage

// File: rtl/new_decoder_core.sv
// Purely combinational enable-gated N-to-2**N one-hot decode.
// Reusable without the register stage of new_decoder.
module new_decoder_core
    import new_decoder_pkg::*;
#(
    parameter int N = DEFAULT_N,
    localparam int W = 2 ** N
) (
    input  logic         en,
    input  logic [N-1:0] in,
    output logic [W-1:0] dec
);

    logic [N_MAX-1:0] code;
    logic [W_MAX-1:0] dec_full;

    // Gating with en also hides any unknown value on `in` while disabled.
    always_comb begin
        code     = N_MAX'(in);
        dec_full = onehot_of(code);
        dec      = en ? dec_full[W-1:0] : '0;
    end

    // Bits above W are always zero because `in` cannot exceed W-1.
    if (W < W_MAX) begin : g_hi
        logic unused_hi;
        assign unused_hi = |dec_full[W_MAX-1:W];
    end

endmodule

// File: rtl/new_decoder.sv
// Registered one-hot decoder with a valid flag and a sticky bitmap
// of every code decoded since reset or the last seen_clr.
module new_decoder
    import new_decoder_pkg::*;
#(
    parameter int N = DEFAULT_N,
    localparam int W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] in,
    input  logic         seen_clr,
    output logic [W-1:0] out,
    output logic         valid,
    output logic [W-1:0] seen
);

    logic [W-1:0] dec;
    logic [W-1:0] out_d,   out_q;
    logic         valid_d, valid_q;
    logic [W-1:0] seen_d,  seen_q;

    new_decoder_core #(.N(N)) u_core (
        .en  (en),
        .in  (in),
        .dec (dec)
    );

    // The clear applies before the current decode, so a same-cycle hit survives.
    always_comb begin
        out_d   = dec;
        valid_d = en;
        seen_d  = (seen_clr ? '0 : seen_q) | dec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            seen_q  <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign seen  = seen_q;

endmodule

// File: tb/tb_new_decoder.sv
// Directed bench for new_decoder at N=3 and N=1 with hand-computed expectations.
module tb_new_decoder;

    logic       clk;
    logic       rst_n;
    logic       en, seen_clr;
    logic [2:0] in;
    logic [7:0] out, seen;
    logic       valid;
    logic       en1, seen_clr1;
    logic [0:0] in1;
    logic [1:0] out1, seen1;
    logic       valid1;

    int n_vec = 0;
    int n_err = 0;

    new_decoder #(.N(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in), .seen_clr(seen_clr),
        .out(out), .valid(valid), .seen(seen)
    );

    new_decoder #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .in(in1), .seen_clr(seen_clr1),
        .out(out1), .valid(valid1), .seen(seen1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later and check the invariants.
    task automatic tick;
        @(posedge clk);
        #1;
        check("inv_onehot", 256'($onehot0(out)), 256'(1));
        check("inv_valid", 256'(valid), 256'(out != 8'h00));
        check("inv1_onehot", 256'($onehot0(out1)), 256'(1));
        check("inv1_valid", 256'(valid1), 256'(out1 != 2'b00));
    endtask

    task automatic check3(input string tag, input logic [7:0] e_out, input logic e_valid,
                          input logic [7:0] e_seen);
        check({tag, "_out"}, 256'(out), 256'(e_out));
        check({tag, "_valid"}, 256'(valid), 256'(e_valid));
        check({tag, "_seen"}, 256'(seen), 256'(e_seen));
    endtask

    logic [7:0] toggle_out [3] = '{8'h40, 8'h00, 8'h02};
    logic       toggle_en  [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] toggle_in  [3] = '{3'd6, 3'd6, 3'd1};
    logic [7:0] toggle_seen[3] = '{8'h48, 8'h48, 8'h4A};

    initial begin
        rst_n = 1'b0; en = 1'b1; in = 3'd5; seen_clr = 1'b0;
        en1 = 1'b1; in1 = 1'b1; seen_clr1 = 1'b0;

        // Reset held for two edges overrides en.
        tick; tick;
        check3("reset", 8'h00, 1'b0, 8'h00);
        check("reset1_out", 256'(out1), 256'(0));
        check("reset1_seen", 256'(seen1), 256'(0));
        rst_n = 1'b1; en1 = 1'b0;

        // Disabled sweep.
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in = 3'(i);
            tick;
            check3($sformatf("dis%0d", i), 8'h00, 1'b0, 8'h00);
        end

        // Enabled sweep, seen accumulates.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in = 3'(i);
            tick;
            check3($sformatf("en%0d", i), 8'(1 << i), 1'b1, 8'((2 << i) - 1));
        end
        check("sweep_seen", 256'(seen), 256'(8'hFF));

        // Clear with simultaneous hit keeps only the new code.
        seen_clr = 1'b1; in = 3'd3;
        tick;
        check3("clr_hit", 8'h08, 1'b1, 8'h08);
        seen_clr = 1'b0;

        // Enable toggle.
        for (int i = 0; i < 3; i++) begin
            en = toggle_en[i]; in = toggle_in[i];
            tick;
            check3($sformatf("tog%0d", i), toggle_out[i], toggle_en[i], toggle_seen[i]);
        end

        // Clear without a decode empties the bitmap.
        en = 1'b0; seen_clr = 1'b1;
        tick;
        check3("clr_only", 8'h00, 1'b0, 8'h00);
        seen_clr = 1'b0;

        // Mid-stream reset, then resume.
        en = 1'b1; in = 3'd2;
        tick;
        check3("pre_rst", 8'h04, 1'b1, 8'h04);
        rst_n = 1'b0; in = 3'd5;
        tick;
        check3("mid_rst", 8'h00, 1'b0, 8'h00);
        rst_n = 1'b1; in = 3'd7;
        tick;
        check3("resume", 8'h80, 1'b1, 8'h80);

        // N=1 instance.
        en1 = 1'b1; in1 = 1'b0;
        tick;
        check("n1_in0_out", 256'(out1), 256'(2'b01));
        check("n1_in0_valid", 256'(valid1), 256'(1));
        in1 = 1'b1;
        tick;
        check("n1_in1_out", 256'(out1), 256'(2'b10));
        check("n1_in1_seen", 256'(seen1), 256'(2'b11));
        en1 = 1'b0;
        tick;
        check("n1_dis_out", 256'(out1), 256'(2'b00));
        check("n1_dis_valid", 256'(valid1), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
